mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 8, number of M0 grants a waiting M1 tolerates before forced M1 priority (range 1..255).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 m0_req, m0_we  in  1  CPU port request / write-enable.
REQ-007 m0_addr  in  AW; m0_wdata  in  DW.
REQ-008 m0_gnt  out  1  one-cycle pulse in the issue cycle.
REQ-009 m0_rvalid  out  1  read data valid pulse.
REQ-010 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: debug/display port, same widths and meaning as M0.
REQ-011 rdata  out  DW  shared read data, equal to mem_dout; meaningful only while m0_rvalid or m1_rvalid is high.
REQ-012 mem_addr  out  AW; mem_din  out  DW; mem_we  out  1; mem_dout  in  DW  (synchronous memory, 1-cycle read latency).

Function
REQ-013 FSM states: IDLE, ISSUE; IDLE->ISSUE when m0_req or m1_req is high; ISSUE->IDLE unconditionally.
REQ-014 In IDLE, the winner's we/addr/wdata and owner id are captured into registers.
REQ-015 Winner selection: only one requester -> that requester wins; both -> M0 wins, unless starve_cnt >= STARVE_LIMIT, in which case M1 wins.
REQ-016 starve_cnt (8 bits): +1 when M0 wins while m1_req is high, saturating at STARVE_LIMIT; cleared to 0 when M1 wins; otherwise held.
REQ-017 In ISSUE: mem_addr/mem_din/mem_we are driven from the captured registers and the owner's gnt is 1 for exactly that cycle.
REQ-018 mem_we is 0 in every cycle other than ISSUE with a captured write.
REQ-019 A captured read raises the owner's rvalid in the cycle after ISSUE, for one cycle only; writes produce no rvalid.
REQ-020 Throughput: at most one access per 2 cycles; grant latency from req in IDLE is 1 cycle; read data latency from gnt is 1 cycle.
REQ-021 Requesters hold req/we/addr/wdata stable until gnt and deassert req in the cycle after gnt; req still high in the following IDLE is treated as a new request.
REQ-022 req changes during ISSUE are ignored; the captured request completes unchanged.
REQ-023 m0_gnt and m1_gnt are never high together; m0_rvalid and m1_rvalid are never high together.
REQ-024 Outside ISSUE, mem_addr and mem_din hold their last driven values.

Reset
REQ-025 rst_n low forces immediately: state=IDLE, m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, mem_we=0, mem_addr=0, mem_din=0, starve_cnt=0, owner=M0, captured we=0.
REQ-026 Reset during ISSUE abandons the access: no gnt completion and no rvalid after release.
REQ-027 First request is accepted in the first IDLE cycle after rst_n rises.

Structure
REQ-028 The owner encoding (M0=0, M1=1), FSM state encoding and the STARVE_LIMIT default live in a shared package, mem_arb_pkg.
REQ-029 One sub-module, arb_starve_ctr (saturating counter with clear), holds starve_cnt; all other logic is flat in mem_arbiter.

Verification
REQ-030 Reset, then m0 read of 0x10 with mem holding 0xDEADBEEF: m0_gnt at cycle 1; m0_rvalid at cycle 2 with rdata=0xDEADBEEF; mem_we stays 0.
REQ-031 m1 write addr 0x20, data 0x12345678: m1_gnt for 1 cycle with mem_we=1, mem_addr=0x20, mem_din=0x12345678; no m1_rvalid.
REQ-032 m0 and m1 requests held continuously with STARVE_LIMIT=8: grant order is 8 M0 grants, 1 M1 grant, repeating; gnts never overlap.
REQ-033 Simultaneous req with starve_cnt=3: M0 wins and starve_cnt becomes 4; M1 alone next IDLE: M1 wins and starve_cnt becomes 0.
REQ-034 rst_n low during the ISSUE of an m0 read: m0_rvalid never rises; after rst_n rises, a pending m1_req is granted 1 cycle later.
REQ-035 m0 changes addr from 0x10 to 0x30 during its ISSUE cycle: mem_addr=0x10 for that access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned STARVE_CNT_W     = 8;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts M0 wins that M1 sat through; saturates at LIMIT, cleared when M1 wins.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic                    clr,
  output logic [STARVE_CNT_W-1:0] cnt
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
    return (v >= LIMIT_C) ? LIMIT_C : v + STARVE_CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a 1-cycle synchronous memory: M0 (CPU) normally
// wins, M1 (debug/display) is forced through after STARVE_LIMIT lost rounds.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,

  output logic [DW-1:0] rdata,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  state_e                  state_q, state_d;
  owner_e                  owner_p1;
  logic                    we_p1;
  logic [AW-1:0]           addr_p1;
  logic [DW-1:0]           wdata_p1;
  logic                    m0_rvalid_p2, m1_rvalid_p2;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    capture, m1_wins, issue_rd;
  logic                    starve_inc, starve_clr;

  assign m1_wins    = m1_req && (!m0_req || (starve_cnt >= LIMIT_C));
  assign starve_inc = capture && !m1_wins && m1_req;
  assign starve_clr = capture && m1_wins;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .cnt   (starve_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    mem_we   = 1'b0;
    issue_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          capture = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_IDLE;
        m0_gnt   = (owner_p1 == OWN_M0);
        m1_gnt   = (owner_p1 == OWN_M1);
        mem_we   = we_p1;
        issue_rd = !we_p1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 1: winner's request captured in IDLE, presented to memory during ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_p1 <= OWN_M0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else if (capture) begin
      owner_p1 <= m1_wins ? OWN_M1 : OWN_M0;
      we_p1    <= m1_wins ? m1_we    : m0_we;
      addr_p1  <= m1_wins ? m1_addr  : m0_addr;
      wdata_p1 <= m1_wins ? m1_wdata : m0_wdata;
    end
  end

  // Stage 2: read data returns from memory one cycle after ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_p2 <= 1'b0;
      m1_rvalid_p2 <= 1'b0;
    end else begin
      m0_rvalid_p2 <= issue_rd && (owner_p1 == OWN_M0);
      m1_rvalid_p2 <= issue_rd && (owner_p1 == OWN_M1);
    end
  end

  assign m0_rvalid = m0_rvalid_p2;
  assign m1_rvalid = m1_rvalid_p2;
  assign mem_addr  = addr_p1;
  assign mem_din   = wdata_p1;
  assign rdata     = mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a request-level model predicts grants and
// read data; a monitor compares them against what the arbiter presents.
module tb_mem_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;
  logic        mem_we;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  function automatic logic [31:0] init_val(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // synchronous memory, 1-cycle read latency
  logic [31:0] mem [0:255];
  logic        loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_din;
      mem_dout <= mem[mem_addr[7:0]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred that was not expected (t=%0t)", name, $time);
  endtask

  typedef struct {
    int          owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    int          owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    int          cnt;
  } glog_t;

  exp_t        exp_g[$];
  exp_t        exp_r[$];
  glog_t       glog[$];
  logic [31:0] rlog[$];
  logic [31:0] shadow [int];
  int          starve = 0;
  bit          busy   = 0;

  function automatic logic [31:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  // Reference model: one access per two cycles, priority rule with starvation count
  exp_t e_m, r_m;
  int   w_m;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_g.delete();
      exp_r.delete();
      starve = 0;
      busy   = 0;
    end else if (busy) begin
      busy = 0;
    end else if (m0_req || m1_req) begin
      w_m = (m1_req && (!m0_req || starve >= LIMIT)) ? 1 : 0;
      if (w_m == 1) starve = 0;
      else if (m1_req && starve < LIMIT) starve = starve + 1;
      e_m.owner = w_m;
      e_m.we    = w_m ? m1_we    : m0_we;
      e_m.addr  = w_m ? m1_addr  : m0_addr;
      e_m.data  = w_m ? m1_wdata : m0_wdata;
      e_m.cyc   = cyc + 1;
      exp_g.push_back(e_m);
      if (e_m.we) begin
        shadow[int'(e_m.addr[7:0])] = e_m.data;
      end else begin
        r_m.owner = w_m;
        r_m.we    = 1'b0;
        r_m.addr  = e_m.addr;
        r_m.data  = shadow_rd(int'(e_m.addr[7:0]));
        r_m.cyc   = cyc + 2;
        exp_r.push_back(r_m);
      end
      busy = 1;
    end
  end

  // Monitor
  exp_t  e_c;
  glog_t g_c;
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_gnt || m1_gnt) begin
        check("gnt_exclusive", 64'(m0_gnt & m1_gnt), 64'd0);
        g_c.owner = m1_gnt ? 1 : 0;
        g_c.we    = mem_we;
        g_c.addr  = mem_addr;
        g_c.din   = mem_din;
        g_c.cnt   = int'(dut.starve_cnt);
        glog.push_back(g_c);
        if (exp_g.size() == 0) begin
          fail("gnt_unexpected");
        end else begin
          e_c = exp_g.pop_front();
          check("gnt_owner", 64'(g_c.owner), 64'(e_c.owner));
          check("gnt_cycle", 64'(cyc), 64'(e_c.cyc));
          check("gnt_mem_we", 64'(mem_we), 64'(e_c.we));
          check("gnt_mem_addr", 64'(mem_addr), 64'(e_c.addr));
          if (e_c.we) check("gnt_mem_din", 64'(mem_din), 64'(e_c.data));
        end
      end else begin
        check("mem_we_outside_issue", 64'(mem_we), 64'd0);
      end
      if (m0_rvalid || m1_rvalid) begin
        check("rvalid_exclusive", 64'(m0_rvalid & m1_rvalid), 64'd0);
        rlog.push_back(rdata);
        if (exp_r.size() == 0) begin
          fail("rvalid_unexpected");
        end else begin
          e_c = exp_r.pop_front();
          check("rvalid_owner", 64'(m1_rvalid ? 1 : 0), 64'(e_c.owner));
          check("rvalid_cycle", 64'(cyc), 64'(e_c.cyc));
          check("rdata", 64'(rdata), 64'(e_c.data));
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m0_gnt"},    64'(m0_gnt),    64'd0);
    check({tag, "_m1_gnt"},    64'(m1_gnt),    64'd0);
    check({tag, "_m0_rvalid"}, 64'(m0_rvalid), 64'd0);
    check({tag, "_m1_rvalid"}, 64'(m1_rvalid), 64'd0);
    check({tag, "_mem_we"},    64'(mem_we),    64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_din"},   64'(mem_din),   64'd0);
    check({tag, "_starve"},    64'(dut.starve_cnt), 64'd0);
  endtask

  // Presents one request and holds it until granted; entered just after a rising edge.
  task automatic issue(input int m, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input bit hold);
    int  n;
    logic g;
    n = 0;
    if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = data; end
    else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = data; end
    do begin
      @(negedge clk);
      n++;
      g = (m == 0) ? m0_gnt : m1_gnt;
    end while (!g && n < 200);
    if (!g) fail("gnt_timeout");
    sync();
    if (!hold) begin
      if (m == 0) m0_req = 0; else m1_req = 0;
    end
  endtask

  task automatic run_random(input int m, input int cnt);
    int gaps[];
    gaps = new[cnt];
    foreach (gaps[i]) gaps[i] = $urandom_range(0, 3);
    for (int i = 0; i < cnt; i++) begin
      repeat (gaps[i]) sync();
      issue(m, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
            (i < cnt - 1) && (gaps[i+1] == 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  bit rv_seen;
  int gi;

  initial begin
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) sync();
    check_reset_outputs("reset");
    rst_n = 1;

    // m0 read of 0x10 straight after reset
    glog.delete(); rlog.delete();
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
    repeat (3) sync();
    check("r030_gnt_count", 64'(glog.size()), 64'd1);
    if (glog.size() > 0) check("r030_mem_we", 64'(glog[0].we), 64'd0);
    check("r030_rvalid_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() > 0) check("r030_rdata", 64'(rlog[0]), 64'hDEADBEEF);

    // m1 write
    glog.delete(); rlog.delete();
    issue(1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    repeat (3) sync();
    check("r031_gnt_count", 64'(glog.size()), 64'd1);
    if (glog.size() > 0) begin
      check("r031_owner", 64'(glog[0].owner), 64'd1);
      check("r031_mem_we", 64'(glog[0].we), 64'd1);
      check("r031_mem_addr", 64'(glog[0].addr), 64'h20);
      check("r031_mem_din", 64'(glog[0].din), 64'h12345678);
    end
    check("r031_no_rvalid", 64'(rlog.size()), 64'd0);

    // both ports requesting continuously
    glog.delete();
    fork
      for (int i = 0; i < 16; i++) issue(0, 1'b0, 32'($urandom_range(0, 255)), 32'h0, i < 15);
      for (int i = 0; i < 2; i++)  issue(1, 1'b0, 32'($urandom_range(0, 255)), 32'h0, i < 1);
    join
    repeat (3) sync();
    check("r032_gnt_count", 64'(glog.size()), 64'd18);
    gi = 0;
    foreach (glog[i]) begin
      check($sformatf("r032_order_%0d", i), 64'(glog[i].owner), 64'((i % 9) == 8 ? 1 : 0));
      gi++;
    end

    // starvation count walks 1..4 then clears when M1 gets through
    glog.delete();
    fork
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'h40 + 32'(i), 32'h0, i < 3);
      issue(1, 1'b1, 32'h60, 32'hA5A5_0001, 1'b0);
    join
    repeat (3) sync();
    check("r033_gnt_count", 64'(glog.size()), 64'd5);
    if (glog.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("r033_owner_%0d", i), 64'(glog[i].owner), 64'd0);
        check($sformatf("r033_cnt_%0d", i), 64'(glog[i].cnt), 64'(i + 1));
      end
      check("r033_m1_owner", 64'(glog[4].owner), 64'd1);
      check("r033_m1_cnt", 64'(glog[4].cnt), 64'd0);
    end

    // address change during ISSUE is ignored
    glog.delete(); rlog.delete();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    gi = 0;
    do begin @(negedge clk); gi++; end while (!m0_gnt && gi < 20);
    check("r035_gnt", 64'(m0_gnt), 64'd1);
    m0_addr = 32'h30;
    #1;
    check("r035_mem_addr", 64'(mem_addr), 64'h10);
    sync();
    m0_req = 0;
    repeat (3) sync();
    check("r035_rvalid_count", 64'(rlog.size()), 64'd1);
    if (rlog.size() > 0) check("r035_rdata", 64'(rlog[0]), 64'(shadow_rd('h10)));

    // reset during ISSUE of an m0 read with m1 pending
    m0_req = 1; m0_we = 0; m0_addr = 32'h44;
    m1_req = 1; m1_we = 1; m1_addr = 32'h50; m1_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #2;
    check("r034_pre_gnt", 64'(m0_gnt), 64'd1);
    rst_n = 0;
    #1;
    check_reset_outputs("r034_async");
    m0_req = 0;
    rv_seen = 0;
    repeat (2) begin @(negedge clk); rv_seen |= m0_rvalid; end
    sync();
    rst_n = 1;
    @(negedge clk);
    rv_seen |= m0_rvalid;
    check("r034_gnt_not_yet", 64'(m1_gnt), 64'd0);
    @(negedge clk);
    rv_seen |= m0_rvalid;
    check("r034_m1_gnt", 64'(m1_gnt), 64'd1);
    sync();
    m1_req = 0;
    repeat (3) begin @(negedge clk); rv_seen |= m0_rvalid; end
    check("r034_no_m0_rvalid", 64'(rv_seen), 64'd0);
    sync();

    // randomized traffic on both ports
    fork
      run_random(0, 40);
      run_random(1, 40);
    join
    repeat (5) sync();
    check("end_gnt_queue_empty", 64'(exp_g.size()), 64'd0);
    check("end_rvalid_queue_empty", 64'(exp_r.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
